// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared state encoding and timing defaults for button conditioning
package btn_pkg;

  localparam int CLK_HZ      = 50_000_000;
  localparam int DEBOUNCE_MS = 10;

  typedef enum logic [1:0] {
    RELEASED     = 2'b00,
    WAIT_PRESS   = 2'b01,
    PRESSED      = 2'b10,
    WAIT_RELEASE = 2'b11
  } btn_state_t;

  function automatic int debounce_cycles(input int clk_hz, input int ms);
    return (clk_hz / 1000) * ms;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - N-flop metastability synchroniser resetting to the idle pin level
module sync_ff #(
  parameter int STAGES    = 2,
  parameter bit RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {STAGES{RESET_VAL}};
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - push-button synchroniser, stability filter and press/release strobes
module btn_debounce
  import btn_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int STABLE_CYCLES  = debounce_cycles(CLK_HZ, DEBOUNCE_MS),
  parameter bit BTN_ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_db,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int             CNT_W    = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic sync_q;
  logic p;

  btn_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pressed_d, btn_db_d, press_pulse_d, release_pulse_d;

  sync_ff #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (BTN_ACTIVE_LOW)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn_raw),
    .q     (sync_q)
  );

  assign p = sync_q ^ BTN_ACTIVE_LOW;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RELEASED;
      cnt_q         <= '0;
      pressed       <= 1'b0;
      btn_db        <= BTN_ACTIVE_LOW;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pressed       <= pressed_d;
      btn_db        <= btn_db_d;
      press_pulse   <= press_pulse_d;
      release_pulse <= release_pulse_d;
    end
  end

  // Any reversal of p inside a WAIT state drops back with cnt cleared: no partial credit.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    pressed_d       = pressed;
    press_pulse_d   = 1'b0;
    release_pulse_d = 1'b0;

    case (state_q)
      RELEASED: begin
        pressed_d = 1'b0;
        if (p) begin
          state_d = WAIT_PRESS;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      WAIT_PRESS: begin
        if (!p) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d       = PRESSED;
          cnt_d         = '0;
          pressed_d     = 1'b1;
          press_pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        pressed_d = 1'b1;
        if (!p) begin
          state_d = WAIT_RELEASE;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      WAIT_RELEASE: begin
        if (p) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d         = RELEASED;
          cnt_d           = '0;
          pressed_d       = 1'b0;
          release_pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d   = RELEASED;
        cnt_d     = '0;
        pressed_d = 1'b0;
      end
    endcase

    btn_db_d = pressed_d ^ BTN_ACTIVE_LOW;
  end

endmodule

// File: doc/btn_debounce.md
Name: btn_debounce

Overview:
- Upstream conditioning stage for the LED-sequencer FSM. Takes a raw mechanical push-button pin and produces the clean debounced level that drives the FSM's b_in.
- Synchronises the asynchronous pin into clk, then filters bounce with a stability counter and a 4-state machine.
- Also emits one-cycle press/release pulses, so later consumers need no local edge detector.

Parameters:
- SYNC_STAGES, 2: number of metastability flops on btn_raw; legal range 2..4.
- STABLE_CYCLES, 500000: consecutive clk cycles the synchronised level must hold before it is accepted (10 ms at 50 MHz); minimum 2.
- BTN_ACTIVE_LOW, 1: 1 means pressed = 0 on the pin; 0 means pressed = 1.
- CNT_W, $clog2(STABLE_CYCLES): stability counter width. Derived; not for override.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- btn_raw  input  1  raw button pin; asynchronous to clk; bouncy
- btn_db  output  1  debounced level, same polarity as the pin
- pressed  output  1  debounced logical state; 1 = button held, independent of polarity
- press_pulse  output  1  single-cycle strobe on an accepted press
- release_pulse  output  1  single-cycle strobe on an accepted release

Behaviour:
- Reset and clocking:
  - Clock is clk. Reset is rst_n, asynchronous assert, active-low. All flops are reset, including the synchroniser.
  - Reset values: state RELEASED; btn_db = BTN_ACTIVE_LOW (the idle pin level); pressed = 0; both pulses = 0; counter = 0; synchroniser flops = the idle level.
- Synchroniser: a SYNC_STAGES-deep flop chain on btn_raw. Its output sync_q is the only signal the FSM examines. Then p = sync_q XOR BTN_ACTIVE_LOW, i.e. 1 = pressed.
- States:
  - RELEASED: if p = 1, go to WAIT_PRESS and set cnt = 1. Otherwise stay and hold cnt = 0.
  - WAIT_PRESS:
    - If p = 0: bounce. Return to RELEASED, cnt = 0, no pulse.
    - Else if cnt == STABLE_CYCLES-1: go to PRESSED, cnt = 0. On the same edge, pressed <= 1, btn_db toggles, and press_pulse <= 1 for exactly one cycle.
    - Else cnt++.
  - PRESSED: mirror of RELEASED. If p = 0, go to WAIT_RELEASE with cnt = 1.
  - WAIT_RELEASE:
    - If p = 1: return to PRESSED, cnt = 0, no pulse.
    - Else if cnt == STABLE_CYCLES-1: go to RELEASED. On the same edge, pressed <= 0, btn_db toggles, and release_pulse <= 1 for one cycle.
    - Else cnt++.
- Outputs: all outputs are registered; there are no combinational paths from btn_raw.
- Latency: a clean pin change first captured at edge k updates btn_db at edge k + SYNC_STAGES - 1 + STABLE_CYCLES.
- Pulse rules:
  - press_pulse and release_pulse are never high together.
  - Minimum spacing between successive pulses is STABLE_CYCLES cycles.
- Bounce: any reversal of p during a WAIT state fully restarts qualification. There is no partial credit and no counter carry-over.
- Counter: it never exceeds STABLE_CYCLES-1, so no wrap-around is possible. It is 0 in both stable states.
- Reset mid-WAIT: the block returns immediately to the reset values, and no pulse is produced. After reset release, a pin already held pressed is qualified afresh: one press_pulse after the full latency.
- Illegal state encoding: recover to RELEASED with reset-value outputs on the next edge.

Decomposition:
- Shared package btn_pkg holds:
  - the state encoding localparams: RELEASED = 2'b00, WAIT_PRESS = 2'b01, PRESSED = 2'b10, WAIT_RELEASE = 2'b11;
  - default timing constants: CLK_HZ = 50_000_000, DEBOUNCE_MS = 10.
- One sub-module, sync_ff: a parameterised N-flop synchroniser with reset value = the idle level. It is reused by the other pin inputs.

Test Plan (SYNC_STAGES=2, STABLE_CYCLES=4, BTN_ACTIVE_LOW=1):
- Reset, pin held at 1, run 20 cycles -> btn_db = 1, pressed = 0, no pulses at any time.
- Clean press: pin 1 -> 0 captured at edge 10 -> btn_db = 0, pressed = 1, and press_pulse high for exactly one cycle at edge 15; nothing earlier.
- Bounce: pin 0 for 2 cycles, 1 for 1, 0 for 3, then back to 1 -> no state change and no pulse. Then hold 0 for 4+ cycles -> exactly one press_pulse.
- Clean release after a press: pin 0 -> 1 -> release_pulse one cycle at +5 edges; btn_db = 1; pressed = 0.
- rst_n asserted low while in WAIT_PRESS with cnt = 2 -> outputs return to reset values immediately, no pulse. With the pin still 0 after release -> press_pulse exactly 5 cycles after the first capture edge.
- BTN_ACTIVE_LOW=0 rerun of the clean press (pin 0 -> 1) -> pressed = 1, btn_db = 1, press_pulse at the same latency.
